// File: rtl/io_sync_bank_pkg.sv
// Shared definitions for the input conditioning bank: sizing helper,
// stretch-width defaults and the per-channel output bundle.
package io_sync_bank_pkg;

    localparam int STRETCH_W_SIM   = 4;
    localparam int STRETCH_W_BOARD = 22;
`ifdef FPGA
    localparam int STRETCH_W_DFLT  = STRETCH_W_BOARD;
`else
    localparam int STRETCH_W_DFLT  = STRETCH_W_SIM;
`endif

    typedef struct packed {
        logic sync;
        logic filt;
        logic rise;
        logic fall;
        logic led;
    } ch_out_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/io_sync_bank_if.sv
// Pin-side bundle of the conditioning bank; master is the board wrapper side.
interface io_sync_bank_if
    import io_sync_bank_pkg::*;
#(
    parameter int N_CH = 8
);
    logic [N_CH-1:0] PIN_I;
    logic [N_CH-1:0] BYPASS_I;
    logic [N_CH-1:0] SYNC_O;
    logic [N_CH-1:0] FILT_O;
    logic [N_CH-1:0] RISE_O;
    logic [N_CH-1:0] FALL_O;
    logic [N_CH-1:0] ACT_LED;

    modport master (
        output PIN_I, BYPASS_I,
        input  SYNC_O, FILT_O, RISE_O, FALL_O, ACT_LED
    );

    modport slave (
        input  PIN_I, BYPASS_I,
        output SYNC_O, FILT_O, RISE_O, FALL_O, ACT_LED
    );
endinterface

// File: rtl/io_sync_bank_ch.sv
// One conditioning channel: synchroniser, glitch filter, edge pulses and
// activity-LED stretcher. Every output is a flop or a flop xor a constant.
module io_sync_ch
    import io_sync_bank_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int STRETCH_W   = 4,
    parameter bit RST_BIT     = 1'b0,
    parameter bit INV_BIT     = 1'b0,
    parameter bit LVL_BIT     = 1'b0
) (
    input  logic    CLK,
    input  logic    RSTN,
    input  logic    pin,
    input  logic    bypass,
    output ch_out_t q
);
    localparam int            CW       = clog2(FILT_LEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [STRETCH_W-1:0] str_q;
    logic                 sync, filt_q, filt_d, rise_q, fall_q, led_q;

    assign sync = sync_q[SYNC_STAGES-1] ^ INV_BIT;

    // Any disagreement run that ends early drops its count entirely.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (bypass) begin
            filt_d = sync;
        end else if (sync != filt_q) begin
            if (cnt_q == CNT_LAST) filt_d = sync;
            else                   cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            sync_q <= {SYNC_STAGES{RST_BIT}};
            filt_q <= RST_BIT;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            str_q  <= '0;
            led_q  <= 1'b0;
        end else begin
            sync_q[0] <= pin;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            rise_q <= ~filt_q & filt_d;
            fall_q <= filt_q & ~filt_d;
            if (rise_q | fall_q)  str_q <= '1;
            else if (str_q != '0) str_q <= str_q - STRETCH_W'(1);
            led_q <= LVL_BIT ? filt_q : (str_q != '0);
        end
    end

    assign q = '{sync: sync, filt: filt_q, rise: rise_q, fall: fall_q, led: led_q};

endmodule

// File: rtl/io_sync_bank.sv
// N-channel input conditioning bank between board pins and core/LED logic;
// one io_sync_ch per channel, per-bit masks select reset, inversion and LED mode.
module io_sync_bank
    import io_sync_bank_pkg::*;
#(
    parameter int              N_CH         = 8,
    parameter int              SYNC_STAGES  = 2,
    parameter int              FILT_LEN     = 4,
    parameter int              STRETCH_W    = STRETCH_W_DFLT,
    parameter logic [N_CH-1:0] RST_VAL      = '0,
    parameter logic [N_CH-1:0] INV_MASK     = '0,
    parameter logic [N_CH-1:0] LED_LVL_MASK = '0
) (
    input  logic           CLK,
    input  logic           RSTN,
    io_sync_bank_if.slave  bus
);
    ch_out_t [N_CH-1:0] ch_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        io_sync_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN),
            .STRETCH_W   (STRETCH_W),
            .RST_BIT     (RST_VAL[i]),
            .INV_BIT     (INV_MASK[i]),
            .LVL_BIT     (LED_LVL_MASK[i])
        ) u_ch (
            .CLK    (CLK),
            .RSTN   (RSTN),
            .pin    (bus.PIN_I[i]),
            .bypass (bus.BYPASS_I[i]),
            .q      (ch_q[i])
        );

        assign bus.SYNC_O[i]  = ch_q[i].sync;
        assign bus.FILT_O[i]  = ch_q[i].filt;
        assign bus.RISE_O[i]  = ch_q[i].rise;
        assign bus.FALL_O[i]  = ch_q[i].fall;
        assign bus.ACT_LED[i] = ch_q[i].led;
    end

endmodule

// File: tb/tb_io_sync_bank.sv
// Randomised scoreboard bench for io_sync_bank: a history-based reference
// model predicts every output per cycle, a monitor compares on the falling edge.
module tb_io_sync_bank;
    import io_sync_bank_pkg::*;

    localparam int        N    = 8;
    localparam int        S    = 2;
    localparam int        F    = 4;
    localparam int        W    = 4;
    localparam logic [7:0] RV  = 8'h0F;
    localparam logic [7:0] IM  = 8'h41;
    localparam logic [7:0] LM  = 8'h82;
    localparam int        NCYC = 3000;

    logic CLK = 1'b0;
    logic RSTN;

    io_sync_bank_if #(.N_CH(N)) bus ();

    io_sync_bank #(
        .N_CH(N), .SYNC_STAGES(S), .FILT_LEN(F), .STRETCH_W(W),
        .RST_VAL(RV), .INV_MASK(IM), .LED_LVL_MASK(LM)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [7:0] sync, filt, rise, fall, led;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference history, indexed by posedge number (1..NCYC).
    logic [7:0] h_pin  [0:NCYC];
    logic [7:0] h_sync [0:NCYC];
    logic [7:0] h_filt [0:NCYC];
    logic [7:0] h_edge [0:NCYC];
    bit         h_rst  [0:NCYC];
    int         run    [N];

    task automatic check(input string nm, input int cyc, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Predict outputs after posedge t from the recorded pin/reset/bypass history.
    task automatic model(input int t, input logic [7:0] byp);
        logic [7:0] s, f, e, led, sp, fp;
        bit rr, blocked;
        int idx;
        rr = 1'b0;
        for (int k = 0; k < S; k++)
            if (t - k < 1 || h_rst[t-k]) rr = 1'b1;
        s  = rr ? (RV ^ IM) : (h_pin[t-S+1] ^ IM);
        sp = h_sync[t-1];
        fp = h_filt[t-1];
        for (int c = 0; c < N; c++) begin
            if (h_rst[t]) begin
                f[c] = RV[c]; run[c] = 0;
            end else if (byp[c]) begin
                f[c] = sp[c]; run[c] = 0;
            end else if (sp[c] == fp[c]) begin
                f[c] = fp[c]; run[c] = 0;
            end else begin
                run[c]++;
                if (run[c] >= F) begin f[c] = sp[c]; run[c] = 0; end
                else f[c] = fp[c];
            end
        end
        e = h_rst[t] ? 8'h00 : (f ^ fp);
        h_sync[t] = s;
        h_filt[t] = f;
        h_edge[t] = e;
        for (int c = 0; c < N; c++) begin
            led[c] = 1'b0;
            if (LM[c]) begin
                led[c] = h_rst[t] ? 1'b0 : fp[c];
            end else begin
                // Lit while the latest edge at or before t-2 is within 2^W cycles and no reset since.
                blocked = h_rst[t] || h_rst[t-1];
                for (int k = 2; k <= (1 << W); k++) begin
                    idx = t - k;
                    if (idx < 1) break;
                    if (h_edge[idx][c]) begin
                        led[c] = !blocked;
                        break;
                    end
                    blocked = blocked || h_rst[idx];
                end
            end
        end
        sb.push_back('{cyc: t, sync: s, filt: f, rise: e & f, fall: e & ~f, led: led});
    endtask

    initial begin
        logic [7:0] pin, byp;
        int rst_left, mode;
        bit cur_rst;
        pin = 8'hA5; byp = 8'h00; rst_left = 0;
        for (int t = 1; t <= NCYC; t++) begin
            if (t <= 3) cur_rst = 1'b1;
            else if (t <= 20) cur_rst = 1'b0;
            else begin
                if (rst_left == 0 && $urandom_range(199, 0) == 0) rst_left = $urandom_range(3, 1);
                cur_rst = (rst_left > 0);
                if (rst_left > 0) rst_left--;
                mode = (t / 250) % 4;
                for (int c = 0; c < N; c++) begin
                    case (mode)
                        0: if ($urandom_range(15, 0) == 0) pin[c] = ~pin[c];
                        1: if ($urandom_range(2, 0) == 0)  pin[c] = ~pin[c];
                        2: begin
                            if ($urandom_range(4, 0) == 0)  pin[c] = ~pin[c];
                            if ($urandom_range(19, 0) == 0) byp[c] = ~byp[c];
                        end
                        default: if ($urandom_range(1, 0) == 0) pin[c] = ~pin[c];
                    endcase
                end
                if (mode < 2) byp = 8'h00;
                else if (mode == 3 && t % 8 == 0) byp = 8'($urandom());
            end
            RSTN = ~cur_rst;
            bus.PIN_I = pin;
            bus.BYPASS_I = byp;
            h_pin[t] = pin;
            h_rst[t] = cur_rst;
            model(t, byp);
            @(posedge CLK);
            #1;
        end
    end

    initial begin
        exp_t x;
        for (int i = 0; i < NCYC; i++) begin
            @(negedge CLK);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty cycle %0d: got no expectation, required one", i + 1);
            end else begin
                x = sb.pop_front();
                check("sync", x.cyc, bus.SYNC_O,  x.sync);
                check("filt", x.cyc, bus.FILT_O,  x.filt);
                check("rise", x.cyc, bus.RISE_O,  x.rise);
                check("fall", x.cyc, bus.FALL_O,  x.fall);
                check("led",  x.cyc, bus.ACT_LED, x.led);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(NCYC * 10 + 1000);
        $display("FAIL timeout: simulation did not complete within %0d cycles", NCYC + 100);
        $fatal(1);
    end

endmodule
